// File: rtl/apb_bridge_pkg.sv
// -----------------------------------------------------------------------------
// apb_bridge_pkg
// Shared types and helpers for the AHB-to-APB bridge.
//   state_t     : APB controller FSM states
//   REGION_*    : APB slave address map (three contiguous 64 MiB windows)
//   sel_decode  : address -> one-hot APB slave select (zero when unmapped)
// -----------------------------------------------------------------------------
package apb_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WWAIT,
    ST_READ,
    ST_WRITE,
    ST_WRITEP,
    ST_RENABLE,
    ST_WENABLE,
    ST_WENABLEP
  } state_t;

  localparam int          NUM_REGIONS  = 3;
  localparam logic [31:0] REGION_BASE  = 32'h8000_0000;
  localparam logic [31:0] REGION_SIZE  = 32'h0400_0000;
  localparam logic [31:0] REGION_LIMIT = 32'h8BFF_FFFF;

  // Windows are equal-sized and packed back to back from REGION_BASE, so the
  // slave index is simply the offset divided by the window size.
  function automatic logic [NUM_REGIONS-1:0] sel_decode(input logic [31:0] addr);
    logic [NUM_REGIONS-1:0] sel;
    logic [1:0]             idx;
    sel = '0;
    idx = 2'((addr - REGION_BASE) / REGION_SIZE);
    if (addr >= REGION_BASE && addr <= REGION_LIMIT) begin
      sel = NUM_REGIONS'(1) << idx;
    end
    return sel;
  endfunction

endpackage

// File: rtl/apb_fsm_controller.sv
// -----------------------------------------------------------------------------
// apb_fsm_controller
// APB-side stage of the AHB-to-APB bridge. Takes the pipelined AHB address,
// data and control from the slave interface, runs the APB SETUP/ENABLE
// sequence and returns Hreadyout (fed back upstream as Hreadyin).
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous reset, active low
//   valid      in   AHB transfer accepted this cycle
//   Hwrite     in   current AHB direction
//   Hwritereg  in   Hwrite delayed one cycle
//   Haddr      in   current AHB address
//   Haddr1     in   Haddr delayed one cycle
//   Haddr2     in   Haddr delayed two cycles
//   Hwdata     in   current AHB write data
//   Hwdata1    in   Hwdata delayed one cycle
//   Paddr      out  APB address
//   Pwdata     out  APB write data
//   Pwrite     out  APB direction
//   Pselx      out  one-hot APB slave select (NSLV bits)
//   Penable    out  APB enable
//   Hreadyout  out  AHB ready back to the master
// All outputs are registered.
// -----------------------------------------------------------------------------
module apb_fsm_controller
  import apb_bridge_pkg::*;
#(
  parameter int NSLV = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid,
  input  logic            Hwrite,
  input  logic            Hwritereg,
  input  logic [31:0]     Haddr,
  input  logic [31:0]     Haddr1,
  input  logic [31:0]     Haddr2,
  input  logic [31:0]     Hwdata,
  input  logic [31:0]     Hwdata1,
  output logic [31:0]     Paddr,
  output logic [31:0]     Pwdata,
  output logic            Pwrite,
  output logic [NSLV-1:0] Pselx,
  output logic            Penable,
  output logic            Hreadyout
);

  state_t            state_q, state_d;
  logic [31:0]       paddr_d, pwdata_d;
  logic              pwrite_d, penable_d, hreadyout_d;
  logic [NSLV-1:0]   pselx_d;

  // Per-cycle action requested by the state decode; applied once below so the
  // launch/enable/release output patterns are written in exactly one place.
  logic              do_launch, do_enable, do_release;
  logic              launch_write;
  logic [31:0]       launch_addr, launch_data;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_d      = state_q;
    paddr_d      = Paddr;
    pwdata_d     = Pwdata;
    pwrite_d     = Pwrite;
    pselx_d      = Pselx;
    penable_d    = Penable;
    hreadyout_d  = Hreadyout;
    do_launch    = 1'b0;
    do_enable    = 1'b0;
    do_release   = 1'b0;
    launch_write = 1'b0;
    launch_addr  = Haddr;
    launch_data  = Hwdata;

    unique case (state_q)
      ST_IDLE: begin
        if (valid && !Hwrite) begin
          state_d   = ST_READ;
          do_launch = 1'b1;
        end else if (valid) begin
          // Write data arrives next cycle; keep the master moving meanwhile.
          state_d     = ST_WWAIT;
          hreadyout_d = 1'b1;
        end else begin
          do_release = 1'b1;
        end
      end

      ST_WWAIT: begin
        state_d      = valid ? ST_WRITEP : ST_WRITE;
        do_launch    = 1'b1;
        launch_write = 1'b1;
        launch_addr  = Haddr1;
      end

      ST_READ: begin
        state_d   = ST_RENABLE;
        do_enable = 1'b1;
      end

      ST_WRITE: begin
        state_d   = valid ? ST_WENABLEP : ST_WENABLE;
        do_enable = 1'b1;
      end

      ST_WRITEP: begin
        state_d   = ST_WENABLEP;
        do_enable = 1'b1;
      end

      ST_RENABLE, ST_WENABLE: begin
        if (valid && !Hwrite) begin
          state_d   = ST_READ;
          do_launch = 1'b1;
        end else begin
          state_d    = valid ? ST_WWAIT : ST_IDLE;
          do_release = 1'b1;
        end
      end

      ST_WENABLEP: begin
        // A transfer is already queued: its address/data sit one (read) or
        // two (write) stages back in the upstream pipeline.
        do_launch = 1'b1;
        if (!Hwritereg) begin
          state_d     = ST_READ;
          launch_addr = Haddr1;
        end else begin
          state_d      = valid ? ST_WRITEP : ST_WRITE;
          launch_write = 1'b1;
          launch_addr  = Haddr2;
          launch_data  = Hwdata1;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        paddr_d     = '0;
        pwdata_d    = '0;
        pwrite_d    = 1'b0;
        pselx_d     = '0;
        penable_d   = 1'b0;
        hreadyout_d = 1'b1;
      end
    endcase

    if (do_launch) begin
      paddr_d     = launch_addr;
      pwrite_d    = launch_write;
      pselx_d     = NSLV'(sel_decode(launch_addr));
      penable_d   = 1'b0;
      hreadyout_d = 1'b0;
      if (launch_write) begin
        pwdata_d = launch_data;
      end
    end

    if (do_enable) begin
      penable_d   = 1'b1;
      hreadyout_d = 1'b1;
    end

    if (do_release) begin
      pselx_d     = '0;
      penable_d   = 1'b0;
      hreadyout_d = 1'b1;
    end
  end

  // NOTE: state and outputs use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      Paddr     <= '0;
      Pwdata    <= '0;
      Pwrite    <= 1'b0;
      Pselx     <= '0;
      Penable   <= 1'b0;
      Hreadyout <= 1'b1;
    end else begin
      state_q   <= state_d;
      Paddr     <= paddr_d;
      Pwdata    <= pwdata_d;
      Pwrite    <= pwrite_d;
      Pselx     <= pselx_d;
      Penable   <= penable_d;
      Hreadyout <= hreadyout_d;
    end
  end

endmodule

// File: tb/tb_apb_fsm_controller.sv
// -----------------------------------------------------------------------------
// tb_apb_fsm_controller
// Directed scenarios with hand-derived expectations, then a randomized run
// compared cycle by cycle against a transaction-level model of the bridge.
// -----------------------------------------------------------------------------
module tb_apb_fsm_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid, hwrite, hwritereg;
  logic [31:0] haddr, haddr1, haddr2, hwdata, hwdata1;
  logic [31:0] paddr, pwdata;
  logic        pwrite, penable, hreadyout;
  logic [2:0]  pselx;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  apb_fsm_controller #(.NSLV(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid     (valid),
    .Hwrite    (hwrite),
    .Hwritereg (hwritereg),
    .Haddr     (haddr),
    .Haddr1    (haddr1),
    .Haddr2    (haddr2),
    .Hwdata    (hwdata),
    .Hwdata1   (hwdata1),
    .Paddr     (paddr),
    .Pwdata    (pwdata),
    .Pwrite    (pwrite),
    .Pselx     (pselx),
    .Penable   (penable),
    .Hreadyout (hreadyout)
  );

  // Observed bus: control view (no write data) and full view.
  logic [37:0] obs_ctl;
  logic [69:0] obs_all;
  assign obs_ctl = {paddr, pwrite, pselx, penable, hreadyout};
  assign obs_all = {paddr, pwdata, pwrite, pselx, penable, hreadyout};

  // ---------------------------------------------------------------------------
  // Reference model: tracks the APB transaction in flight as a protocol phase
  // (nothing / waiting for write data / setup / access) plus whether another
  // transfer is already queued behind it, and predicts the APB bus.
  // ---------------------------------------------------------------------------
  typedef enum {M_NONE, M_DATA_WAIT, M_SETUP, M_ACCESS} mphase_t;
  mphase_t     m_phase;
  logic        m_pipe, m_write;
  logic [31:0] e_paddr, e_pwdata;
  logic        e_pwrite, e_pen, e_hrdy;
  logic [2:0]  e_psel;

  function automatic logic [2:0] sel_of(input logic [31:0] a);
    if (a < 32'h8000_0000 || a > 32'h8BFF_FFFF) return 3'b000;
    if (a < 32'h8400_0000) return 3'b001;
    if (a < 32'h8800_0000) return 3'b010;
    return 3'b100;
  endfunction

  task automatic model_start(input logic w, input logic [31:0] a, input logic [31:0] d);
    m_phase  = M_SETUP;
    m_write  = w;
    e_paddr  = a;
    e_pwrite = w;
    if (w) e_pwdata = d;
    e_psel   = sel_of(a);
    e_pen    = 1'b0;
    e_hrdy   = 1'b0;
  endtask

  task automatic model_advance();
    if (!rst) begin
      m_phase = M_NONE; m_pipe = 1'b0; m_write = 1'b0;
      e_paddr = '0; e_pwdata = '0; e_pwrite = 1'b0;
      e_psel = '0; e_pen = 1'b0; e_hrdy = 1'b1;
    end else if (m_phase == M_SETUP) begin
      // Second APB cycle; a write keeps/gains a queued follow-on if one shows up.
      e_pen   = 1'b1;
      e_hrdy  = 1'b1;
      m_pipe  = m_write & (m_pipe | valid);
      m_phase = M_ACCESS;
    end else if (m_phase == M_DATA_WAIT) begin
      model_start(1'b1, haddr1, hwdata);
      m_pipe = valid;
    end else if (m_phase == M_ACCESS && m_pipe) begin
      if (!hwritereg) begin
        model_start(1'b0, haddr1, 32'h0);
        m_pipe = 1'b0;
      end else begin
        model_start(1'b1, haddr2, hwdata1);
        m_pipe = valid;
      end
    end else if (valid && !hwrite) begin
      model_start(1'b0, haddr, 32'h0);
      m_pipe = 1'b0;
    end else begin
      m_phase = valid ? M_DATA_WAIT : M_NONE;
      e_psel  = '0;
      e_pen   = 1'b0;
      e_hrdy  = 1'b1;
    end
  endtask

  // One clock: update the model from the pre-edge inputs, let the edge happen,
  // then shift the upstream pipeline the way the slave interface would.
  task automatic drive_cycle();
    model_advance();
    @(posedge clk);
    #1;
    haddr2    = haddr1;
    haddr1    = haddr;
    hwdata1   = hwdata;
    hwritereg = hwrite;
  endtask

  task automatic apply_reset();
    rst = 1'b0; valid = 1'b0; hwrite = 1'b0; haddr = '0; hwdata = '0;
    drive_cycle();
    rst = 1'b1;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 7))
      0: return 32'h8000_0000;
      1: return 32'h83FF_FFFC;
      2: return 32'h8400_0000;
      3: return 32'h8BFF_FFFC;
      4: return 32'h8C00_0000;
      5: return 32'h7FFF_FFFC;
      default: return 32'h8000_0000 + (r % 32'h0C00_0000);
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [69:0] exp;
    exp = {32'h0, 32'h0, 1'b0, 3'b000, 1'b0, 1'b1};
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      valid = 1'($urandom); hwrite = 1'($urandom);
      haddr = rand_addr(); hwdata = $urandom;
      drive_cycle();
      n_checks++;
      if (obs_all !== exp) begin
        n_fail++;
        $display("FAIL reset_%0d: bus=%h expected %h", i, obs_all, exp);
      end
    end
    rst = 1'b1; valid = 1'b0;
  endtask

  task automatic test_single_read();
    logic [37:0] exp;
    apply_reset();
    valid = 1'b1; hwrite = 1'b0; haddr = 32'h8000_0010; hwdata = $urandom;
    drive_cycle();
    exp = {32'h8000_0010, 1'b0, 3'b001, 1'b0, 1'b0};
    n_checks++;
    if (obs_ctl !== exp) begin n_fail++; $display("FAIL rd_setup: ctl=%h expected %h", obs_ctl, exp); end
    valid = 1'b0;
    drive_cycle();
    exp = {32'h8000_0010, 1'b0, 3'b001, 1'b1, 1'b1};
    n_checks++;
    if (obs_ctl !== exp) begin n_fail++; $display("FAIL rd_enable: ctl=%h expected %h", obs_ctl, exp); end
    drive_cycle();
    exp = {32'h8000_0010, 1'b0, 3'b000, 1'b0, 1'b1};
    n_checks++;
    if (obs_ctl !== exp) begin n_fail++; $display("FAIL rd_release: ctl=%h expected %h", obs_ctl, exp); end
  endtask

  task automatic test_single_write();
    logic [69:0] exp;
    apply_reset();
    valid = 1'b1; hwrite = 1'b1; haddr = 32'h8400_0004;
    drive_cycle();
    exp = {32'h0, 32'h0, 1'b0, 3'b000, 1'b0, 1'b1};
    n_checks++;
    if (obs_all !== exp) begin n_fail++; $display("FAIL wr_wait: bus=%h expected %h", obs_all, exp); end
    valid = 1'b0; hwrite = 1'b0; haddr = 32'h0; hwdata = 32'hDEAD_BEEF;
    drive_cycle();
    exp = {32'h8400_0004, 32'hDEAD_BEEF, 1'b1, 3'b010, 1'b0, 1'b0};
    n_checks++;
    if (obs_all !== exp) begin n_fail++; $display("FAIL wr_setup: bus=%h expected %h", obs_all, exp); end
    drive_cycle();
    exp = {32'h8400_0004, 32'hDEAD_BEEF, 1'b1, 3'b010, 1'b1, 1'b1};
    n_checks++;
    if (obs_all !== exp) begin n_fail++; $display("FAIL wr_enable: bus=%h expected %h", obs_all, exp); end
    drive_cycle();
    exp = {32'h8400_0004, 32'hDEAD_BEEF, 1'b1, 3'b000, 1'b0, 1'b1};
    n_checks++;
    if (obs_all !== exp) begin n_fail++; $display("FAIL wr_release: bus=%h expected %h", obs_all, exp); end
  endtask

  task automatic test_back_to_back();
    logic [69:0] exp;
    int          enable_cycles;
    apply_reset();
    valid = 1'b1; hwrite = 1'b1; haddr = 32'h8800_0000;
    drive_cycle();                                   // WWAIT
    valid = 1'b1; hwrite = 1'b1; haddr = 32'h8800_0004; hwdata = 32'h1;
    drive_cycle();                                   // first SETUP, second queued
    exp = {32'h8800_0000, 32'h1, 1'b1, 3'b100, 1'b0, 1'b0};
    n_checks++;
    if (obs_all !== exp) begin n_fail++; $display("FAIL b2b_setup0: bus=%h expected %h", obs_all, exp); end
    valid = 1'b0; hwrite = 1'b1; hwdata = 32'h2;     // master stalled, data of A1 held
    drive_cycle();
    exp = {32'h8800_0000, 32'h1, 1'b1, 3'b100, 1'b1, 1'b1};
    n_checks++;
    if (obs_all !== exp) begin n_fail++; $display("FAIL b2b_enable0: bus=%h expected %h", obs_all, exp); end
    valid = 1'b0; hwrite = 1'b0; haddr = 32'h0;
    drive_cycle();
    exp = {32'h8800_0004, 32'h2, 1'b1, 3'b100, 1'b0, 1'b0};
    n_checks++;
    if (obs_all !== exp) begin n_fail++; $display("FAIL b2b_setup1: bus=%h expected %h", obs_all, exp); end
    enable_cycles = 0;
    for (int i = 0; i < 3; i++) begin
      drive_cycle();
      if (penable === 1'b1) enable_cycles++;
    end
    n_checks++;
    if (enable_cycles !== 1) begin
      n_fail++;
      $display("FAIL b2b_enable1_count: cycles=%0d expected 1", enable_cycles);
    end
    exp = {32'h8800_0004, 32'h2, 1'b1, 3'b000, 1'b0, 1'b1};
    n_checks++;
    if (obs_all !== exp) begin n_fail++; $display("FAIL b2b_done: bus=%h expected %h", obs_all, exp); end
  endtask

  task automatic test_write_then_read();
    logic [37:0] exp;
    apply_reset();
    valid = 1'b1; hwrite = 1'b1; haddr = 32'h8400_0000;
    drive_cycle();                                   // WWAIT
    valid = 1'b1; hwrite = 1'b0; haddr = 32'h8000_0008; hwdata = 32'h5555_AAAA;
    drive_cycle();                                   // write SETUP, read queued
    valid = 1'b0;                                    // stalled; read address held
    drive_cycle();                                   // write ENABLE
    exp = {32'h8400_0000, 1'b1, 3'b010, 1'b1, 1'b1};
    n_checks++;
    if (obs_ctl !== exp) begin n_fail++; $display("FAIL wr_rd_wenable: ctl=%h expected %h", obs_ctl, exp); end
    haddr = 32'h0;
    drive_cycle();
    exp = {32'h8000_0008, 1'b0, 3'b001, 1'b0, 1'b0};
    n_checks++;
    if (obs_ctl !== exp) begin n_fail++; $display("FAIL wr_rd_setup: ctl=%h expected %h", obs_ctl, exp); end
    drive_cycle();
    exp = {32'h8000_0008, 1'b0, 3'b001, 1'b1, 1'b1};
    n_checks++;
    if (obs_ctl !== exp) begin n_fail++; $display("FAIL wr_rd_enable: ctl=%h expected %h", obs_ctl, exp); end
  endtask

  task automatic test_reset_mid_transfer();
    logic [69:0] exp;
    logic [37:0] exp_c;
    apply_reset();
    valid = 1'b1; hwrite = 1'b1; haddr = 32'h8000_0100;
    drive_cycle();                                   // WWAIT
    valid = 1'b0; hwrite = 1'b0; hwdata = 32'hCAFE_0001;
    drive_cycle();                                   // SETUP
    drive_cycle();                                   // ENABLE
    rst = 1'b0; valid = 1'b1; hwrite = 1'b0; haddr = 32'h8400_0000;
    drive_cycle();
    exp = {32'h0, 32'h0, 1'b0, 3'b000, 1'b0, 1'b1};
    n_checks++;
    if (obs_all !== exp) begin n_fail++; $display("FAIL midrst_abort: bus=%h expected %h", obs_all, exp); end
    rst = 1'b1; valid = 1'b1; hwrite = 1'b0; haddr = 32'h8800_0020;
    drive_cycle();
    exp_c = {32'h8800_0020, 1'b0, 3'b100, 1'b0, 1'b0};
    n_checks++;
    if (obs_ctl !== exp_c) begin n_fail++; $display("FAIL midrst_rd_setup: ctl=%h expected %h", obs_ctl, exp_c); end
    valid = 1'b0;
    drive_cycle();
    exp_c = {32'h8800_0020, 1'b0, 3'b100, 1'b1, 1'b1};
    n_checks++;
    if (obs_ctl !== exp_c) begin n_fail++; $display("FAIL midrst_rd_enable: ctl=%h expected %h", obs_ctl, exp_c); end
  endtask

  task automatic test_random();
    logic [69:0] exp;
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      rst    = ($urandom_range(0, 199) != 0);
      valid  = e_hrdy && ($urandom_range(0, 2) != 0);   // upstream honours ready
      hwrite = 1'($urandom);
      haddr  = rand_addr();
      hwdata = $urandom;
      drive_cycle();
      exp = {e_paddr, e_pwdata, e_pwrite, e_psel, e_pen, e_hrdy};
      n_checks++;
      if (obs_all !== exp) begin
        n_fail++;
        $display("FAIL random_cycle_%0d: bus=%h expected %h", i, obs_all, exp);
      end
    end
    rst = 1'b1; valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; valid = 1'b0; hwrite = 1'b0; hwritereg = 1'b0;
    haddr = '0; haddr1 = '0; haddr2 = '0; hwdata = '0; hwdata1 = '0;
    m_phase = M_NONE; m_pipe = 1'b0; m_write = 1'b0;
    e_paddr = '0; e_pwdata = '0; e_pwrite = 1'b0;
    e_psel = '0; e_pen = 1'b0; e_hrdy = 1'b1;

    test_reset();
    test_single_read();
    test_single_write();
    test_back_to_back();
    test_write_then_read();
    test_reset_mid_transfer();
    test_random();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
